// File: rtl/lstm_pkg.sv
// ============================================================================
// lstm_pkg : shared types, defaults and the signed clamp for lstm_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package lstm_pkg;

  localparam int LSTM_DW = 16;
  localparam int LSTM_FW = 8;
  localparam logic [LSTM_DW-1:0] LSTM_C_CLIP = 16'h0400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } lstm_state_t;

  // lim is assumed positive; result lies in [-lim, +lim]
  function automatic logic signed [LSTM_DW-1:0] sat_signed(
    input logic signed [LSTM_DW-1:0] v,
    input logic signed [LSTM_DW-1:0] lim
  );
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lstm_cstate_sat.sv
// ============================================================================
// lstm_cstate_sat : combinational clamp of the cell state to [-C_CLIP, +C_CLIP]
// Rev 1.0
// ============================================================================
`default_nettype none

module lstm_cstate_sat
  import lstm_pkg::*;
#(
  parameter int                    DATA_WIDTH = LSTM_DW,
  parameter logic [DATA_WIDTH-1:0] C_CLIP     = DATA_WIDTH'(LSTM_C_CLIP)
) (
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out
);

  generate
    if (DATA_WIDTH == LSTM_DW) begin : g_pkg_fn
      assign d_out = sat_signed(d_in, C_CLIP);
    end else begin : g_native
      logic signed [DATA_WIDTH-1:0] lim;
      logic signed [DATA_WIDTH-1:0] v;
      assign lim   = signed'(C_CLIP);
      assign v     = signed'(d_in);
      assign d_out = (v > lim)  ? C_CLIP :
                     (v < -lim) ? unsigned'(-lim) : d_in;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
// ============================================================================
// lstm_seq_ctrl : runs a combinational LSTM cell over a framed sample stream.
// Optional macro LSTM_CSAT_EN clamps the stored cell state.   Rev 1.0
// ============================================================================
`default_nettype none

module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int                    DATA_WIDTH  = LSTM_DW,
  parameter int                    FRACT_WIDTH = LSTM_FW,
  parameter int                    CELL_LAT    = 1,
  parameter int                    CNT_W       = 8,
  parameter logic [DATA_WIDTH-1:0] C_CLIP      = DATA_WIDTH'(4 << FRACT_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic                  x_first,
  input  logic                  x_last,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c_in,
  output logic [DATA_WIDTH-1:0] cell_h_in,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic [DATA_WIDTH-1:0] h_data,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic                  h_valid,
  input  logic                  h_ready,
  output logic                  h_last,
  output logic [CNT_W-1:0]      step_cnt
);

  localparam int LAT_W = (CELL_LAT < 2) ? 1 : $clog2(CELL_LAT + 1);

  generate
    if (CELL_LAT < 1 || C_CLIP == '0) begin : g_param_chk
      $error("lstm_seq_ctrl: CELL_LAT must be >= 1 and C_CLIP nonzero");
    end
  endgenerate

  lstm_state_t           state;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] c_reg;
  logic [DATA_WIDTH-1:0] h_reg;
  logic                  last_reg;
  logic [LAT_W-1:0]      settle;
  logic [CNT_W-1:0]      step_reg;
  logic [DATA_WIDTH-1:0] c_next;
  logic                  accept;

`ifdef LSTM_CSAT_EN
  lstm_cstate_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .C_CLIP     (C_CLIP)
  ) u_csat (
    .d_in  (cell_c_out),
    .d_out (c_next)
  );
`else
  assign c_next = cell_c_out;
`endif

  assign accept = x_valid && x_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      x_reg    <= '0;
      c_reg    <= '0;
      h_reg    <= '0;
      last_reg <= 1'b0;
      settle   <= '0;
      step_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_reg    <= x_data;
            last_reg <= x_last;
            if (x_first) begin
              c_reg    <= '0;
              h_reg    <= '0;
              step_reg <= CNT_W'(1);
            end else if (step_reg != '1) begin
              step_reg <= step_reg + CNT_W'(1);
            end
            settle <= LAT_W'(CELL_LAT);
            state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          settle <= settle - LAT_W'(1);
          // settle reads 1 on the last of CELL_LAT held cycles
          if (settle == LAT_W'(1)) begin
            c_reg <= c_next;
            h_reg <= cell_h_out;
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (h_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign x_ready   = (state == ST_IDLE);
  assign h_valid   = (state == ST_OUT);
  assign h_data    = h_reg;
  assign c_data    = c_reg;
  assign h_last    = last_reg;
  assign step_cnt  = step_reg;
  assign cell_x    = x_reg;
  assign cell_c_in = c_reg;
  assign cell_h_in = h_reg;

endmodule

`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
// ============================================================================
// tb_lstm_seq_ctrl : directed bench for lstm_seq_ctrl with a c+=x, h=x cell stub
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lstm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x_data = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic        x_first = 1'b0;
  logic        x_last = 1'b0;
  logic [15:0] cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out;
  logic [15:0] h_data, c_data;
  logic        h_valid;
  logic        h_ready = 1'b1;
  logic        h_last;
  logic [7:0]  step_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign cell_c_out = cell_c_in + cell_x;
  assign cell_h_out = cell_x;

  lstm_seq_ctrl #(
    .DATA_WIDTH  (16),
    .FRACT_WIDTH (8),
    .CELL_LAT    (1),
    .CNT_W       (8),
    .C_CLIP      (16'h0400)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x_data     (x_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_first    (x_first),
    .x_last     (x_last),
    .cell_x     (cell_x),
    .cell_c_in  (cell_c_in),
    .cell_h_in  (cell_h_in),
    .cell_c_out (cell_c_out),
    .cell_h_out (cell_h_out),
    .h_data     (h_data),
    .c_data     (c_data),
    .h_valid    (h_valid),
    .h_ready    (h_ready),
    .h_last     (h_last),
    .step_cnt   (step_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!x_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!x_ready) check("x_ready_timeout", 32'(x_ready), 32'd1);
  endtask

  // one full IDLE->EVAL->OUT->IDLE transaction; h_ready held low for stall cycles in OUT
  task automatic run_step(input logic [15:0] x, input logic first, input logic last,
                          input int stall, input logic [15:0] exp_cin,
                          input logic [15:0] exp_c, input logic [7:0] exp_cnt);
    wait_ready();
    x_data  = x;
    x_first = first;
    x_last  = last;
    x_valid = 1'b1;
    h_ready = (stall == 0);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_first = 1'b0;
    x_last  = 1'b0;
    x_data  = '0;
    @(negedge clk);
    check("eval_c_in", 32'(cell_c_in), 32'(exp_cin));
    check("eval_x", 32'(cell_x), 32'(x));
    check("eval_h_valid", 32'(h_valid), 32'd0);
    check("eval_x_ready", 32'(x_ready), 32'd0);
    @(negedge clk);
    check("out_h_valid", 32'(h_valid), 32'd1);
    check("out_h_data", 32'(h_data), 32'(x));
    check("out_c_data", 32'(c_data), 32'(exp_c));
    check("out_h_last", 32'(h_last), 32'(last));
    check("out_step_cnt", 32'(step_cnt), 32'(exp_cnt));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_h_valid", 32'(h_valid), 32'd1);
      check("stall_h_data", 32'(h_data), 32'(x));
      check("stall_c_data", 32'(c_data), 32'(exp_c));
      check("stall_x_ready", 32'(x_ready), 32'd0);
    end
    h_ready = 1'b1;
    @(negedge clk);
    check("post_x_ready", 32'(x_ready), 32'd1);
    check("post_h_valid", 32'(h_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_pos_c, exp_neg_c, exp_ign_cin, exp_ign_c;
`ifdef LSTM_CSAT_EN
    exp_pos_c   = 16'h0400;
    exp_neg_c   = 16'hFC00;
`else
    exp_pos_c   = 16'h0500;
    exp_neg_c   = 16'hFB00;
`endif
    exp_ign_cin = exp_neg_c;
    exp_ign_c   = exp_neg_c + 16'h0100;

    repeat (3) @(negedge clk);
    check("rst_h_valid", 32'(h_valid), 32'd0);
    check("rst_h_data", 32'(h_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_x_ready", 32'(x_ready), 32'd1);
    check("rel_h_valid", 32'(h_valid), 32'd0);
    check("rel_h_last", 32'(h_last), 32'd0);
    check("rel_step_cnt", 32'(step_cnt), 32'd0);
    check("rel_c_data", 32'(c_data), 32'd0);
    check("rel_cell_x", 32'(cell_x), 32'd0);

    // single-step sequence
    run_step(16'h0100, 1'b1, 1'b1, 0, 16'h0000, 16'h0100, 8'd1);
    // three-step accumulation
    run_step(16'h0100, 1'b1, 1'b0, 0, 16'h0000, 16'h0100, 8'd1);
    run_step(16'h0100, 1'b0, 1'b0, 0, 16'h0100, 16'h0200, 8'd2);
    run_step(16'h0100, 1'b0, 1'b1, 0, 16'h0200, 16'h0300, 8'd3);
    // mid-stream restart with back-pressure
    run_step(16'h0100, 1'b1, 1'b0, 5, 16'h0000, 16'h0100, 8'd1);
    // positive clamp
    run_step(16'h0300, 1'b1, 1'b0, 0, 16'h0000, 16'h0300, 8'd1);
    run_step(16'h0200, 1'b0, 1'b1, 0, 16'h0300, exp_pos_c, 8'd2);
    // negative clamp
    run_step(16'hFD00, 1'b1, 1'b0, 0, 16'h0000, 16'hFD00, 8'd1);
    run_step(16'hFE00, 1'b0, 1'b0, 0, 16'hFD00, exp_neg_c, 8'd2);
    // framing without a handshake is ignored
    x_first = 1'b1;
    x_last  = 1'b1;
    repeat (2) @(negedge clk);
    x_first = 1'b0;
    x_last  = 1'b0;
    run_step(16'h0100, 1'b0, 1'b0, 0, exp_ign_cin, exp_ign_c, 8'd3);

    // reset mid-EVAL discards the pending result
    wait_ready();
    x_data  = 16'h0700;
    x_valid = 1'b1;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    x_data  = '0;
    @(negedge clk);
    check("pre_rst_x_ready", 32'(x_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("async_x_ready", 32'(x_ready), 32'd1);
    check("async_h_valid", 32'(h_valid), 32'd0);
    check("async_c_data", 32'(c_data), 32'd0);
    @(negedge clk);
    check("rst_hold_h_valid", 32'(h_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    // no x_first after reset: zero state, count starts from 1
    run_step(16'h0200, 1'b0, 1'b1, 0, 16'h0000, 16'h0200, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
